// File: rtl/cpu_alu_pkg.sv
// Shared types for the 6502 ALU core and adder hold register.
package cpu_alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        SUMS = 3'b000,
        ANDS = 3'b001,
        EORS = 3'b010,
        ORS  = 3'b011,
        SRS  = 3'b100,
        RSV5 = 3'b101,
        RSV6 = 3'b110,
        RSV7 = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic halfCarry;
        logic zero;
    } alu_flags_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational 6502 ALU: result and flag generation for one operation.
import cpu_alu_pkg::*;

module alu_comb (
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  alu_op_t              op,
    output logic [ALU_WIDTH-1:0] result,
    output alu_flags_t           flags,
    output logic                 op_error
);

    logic [ALU_WIDTH:0] sum;

    // Single 9-bit add shared by SUMS result, carry, overflow and half carry
    assign sum = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, carry_in};

    // Select the result for the requested operation and derive its flags
    always_comb begin
        result   = '0;
        flags    = '0;
        op_error = 1'b0;
        case (op)
            SUMS: begin
                result         = sum[ALU_WIDTH-1:0];
                flags.carry    = sum[ALU_WIDTH];
                flags.overflow = (a[ALU_WIDTH-1] == b[ALU_WIDTH-1]) &&
                                 (sum[ALU_WIDTH-1] != a[ALU_WIDTH-1]);
                // Carry into bit 4 recovered from the sum bit and its operands
                flags.halfCarry = sum[4] ^ a[4] ^ b[4];
            end
            ANDS: result = a & b;
            EORS: result = a ^ b;
            ORS:  result = a | b;
            SRS: begin
                result      = {carry_in, b[ALU_WIDTH-1:1]};
                flags.carry = b[0];
            end
            default: op_error = 1'b1;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/alu_adder_hold.sv
// 6502 ALU core with one-entry adder hold register, handshake and bus gating.
import cpu_alu_pkg::*;

module alu_adder_hold #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] HOLD_RESET = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_REG_IN,
    input  logic [WIDTH-1:0] b_REG_IN,
    input  logic             carryIn,
    input  logic [2:0]       aluOp,
    input  logic             opValid,
    output logic             opReady,
    input  logic             flush,
    output logic             resultValid,
    input  logic             resultReady,
    output logic [WIDTH-1:0] adderHold,
    output logic             carryOut,
    output logic             overflow,
    output logic             halfCarry,
    output logic             zero,
    output logic             opError,
    input  logic             addHoldToAddrLow_EN,
    input  logic             addHoldToSystemBus_EN,
    output logic [WIDTH-1:0] addressLowOut,
    output logic [WIDTH-1:0] systemBusOut
);

    hold_state_t      state;
    logic [WIDTH-1:0] alu_result_p0;
    alu_flags_t       alu_flags_p0;
    logic             alu_err_p0;
    logic             accept;
    logic             pop;

    alu_comb u_alu_comb (
        .a        (a_REG_IN),
        .b        (b_REG_IN),
        .carry_in (carryIn),
        .op       (alu_op_t'(aluOp)),
        .result   (alu_result_p0),
        .flags    (alu_flags_p0),
        .op_error (alu_err_p0)
    );

    // Flush blocks acceptance; a full hold slot frees up when it is popped
    assign opReady     = !flush && ((state == EMPTY) || resultReady);
    assign accept      = opValid && opReady;
    assign resultValid = (state == FULL);
    assign pop         = resultValid && resultReady;

    // ---- stage boundary: combinational ALU -> hold register ----
    // Hold FSM and result/flag capture; outputs only change on accept or reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            adderHold <= HOLD_RESET;
            carryOut  <= 1'b0;
            overflow  <= 1'b0;
            halfCarry <= 1'b0;
            zero      <= (HOLD_RESET == '0);
            opError   <= 1'b0;
        end else begin
            opError <= 1'b0;
            if (flush) begin
                state <= EMPTY;
            end else if (accept) begin
                state     <= FULL;
                adderHold <= alu_result_p0;
                carryOut  <= alu_flags_p0.carry;
                overflow  <= alu_flags_p0.overflow;
                halfCarry <= alu_flags_p0.halfCarry;
                zero      <= alu_flags_p0.zero;
                opError   <= alu_err_p0;
            end else if (pop) begin
                state <= EMPTY;
            end
        end
    end

    // Bus drivers follow the hold register regardless of resultValid
    assign addressLowOut = addHoldToAddrLow_EN   ? adderHold : '0;
    assign systemBusOut  = addHoldToSystemBus_EN ? adderHold : '0;

endmodule

// File: tb/tb_alu_adder_hold.sv
// Directed self-checking bench for alu_adder_hold.
`timescale 1ns/1ps
module tb_alu_adder_hold;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_REG_IN, b_REG_IN;
    logic       carryIn;
    logic [2:0] aluOp;
    logic       opValid, opReady, flush, resultValid, resultReady;
    logic [7:0] adderHold;
    logic       carryOut, overflow, halfCarry, zero, opError;
    logic       addHoldToAddrLow_EN, addHoldToSystemBus_EN;
    logic [7:0] addressLowOut, systemBusOut;

    int n_cmp = 0;
    int n_err = 0;

    // status word: {adderHold, C, V, H, Z, resultValid, opReady}
    logic [13:0] obs;
    assign obs = {adderHold, carryOut, overflow, halfCarry, zero, resultValid, opReady};

    alu_adder_hold #(.WIDTH(8), .HOLD_RESET(8'h00)) dut (
        .clk(clk), .reset(reset), .a_REG_IN(a_REG_IN), .b_REG_IN(b_REG_IN),
        .carryIn(carryIn), .aluOp(aluOp), .opValid(opValid), .opReady(opReady),
        .flush(flush), .resultValid(resultValid), .resultReady(resultReady),
        .adderHold(adderHold), .carryOut(carryOut), .overflow(overflow),
        .halfCarry(halfCarry), .zero(zero), .opError(opError),
        .addHoldToAddrLow_EN(addHoldToAddrLow_EN),
        .addHoldToSystemBus_EN(addHoldToSystemBus_EN),
        .addressLowOut(addressLowOut), .systemBusOut(systemBusOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one operation for exactly one accepting edge, then idle the inputs
    task automatic apply_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic cin);
        aluOp = op; a_REG_IN = a; b_REG_IN = b; carryIn = cin; opValid = 1'b1;
        tick();
        opValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; opValid = 1'b0; flush = 1'b0; resultReady = 1'b1;
        a_REG_IN = 8'h00; b_REG_IN = 8'h00; carryIn = 1'b0; aluOp = 3'b000;
        addHoldToAddrLow_EN = 1'b0; addHoldToSystemBus_EN = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {8'h00, 4'b0001, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_state: got %h want %h", obs, {8'h00, 4'b0001, 2'b01});
        end
        n_cmp++;
        if (opError !== 1'b0) begin
            n_err++; $display("FAIL reset_operr: got %b want 0", opError);
        end
    endtask

    task automatic test_sums();
        // 50+50: signed overflow into negative
        apply_op(3'b000, 8'h50, 8'h50, 1'b0);
        n_cmp++;
        if (obs !== {8'hA0, 4'b0100, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL sums_50_50: got %h want %h", obs, {8'hA0, 4'b0100, 2'b11});
        end
        // FF+01: carry out, half carry, zero
        apply_op(3'b000, 8'hFF, 8'h01, 1'b0);
        n_cmp++;
        if (obs[13:2] !== {8'h00, 4'b1011}) begin
            n_err++; $display("FAIL sums_ff_01: got %h want %h", obs[13:2], {8'h00, 4'b1011});
        end
        // 0F+00+cin: half carry from carry-in
        apply_op(3'b000, 8'h0F, 8'h00, 1'b1);
        n_cmp++;
        if (obs[13:2] !== {8'h10, 4'b0010}) begin
            n_err++; $display("FAIL sums_0f_cin: got %h want %h", obs[13:2], {8'h10, 4'b0010});
        end
    endtask

    task automatic test_logic_shift();
        apply_op(3'b100, 8'h55, 8'h81, 1'b1);
        n_cmp++;
        if (obs[13:2] !== {8'hC0, 4'b1000}) begin
            n_err++; $display("FAIL srs_81: got %h want %h", obs[13:2], {8'hC0, 4'b1000});
        end
        apply_op(3'b010, 8'hF0, 8'hFF, 1'b1);
        n_cmp++;
        if (obs[13:2] !== {8'h0F, 4'b0000}) begin
            n_err++; $display("FAIL eors: got %h want %h", obs[13:2], {8'h0F, 4'b0000});
        end
        apply_op(3'b001, 8'hF0, 8'h3C, 1'b1);
        n_cmp++;
        if (obs[13:2] !== {8'h30, 4'b0000}) begin
            n_err++; $display("FAIL ands: got %h want %h", obs[13:2], {8'h30, 4'b0000});
        end
        apply_op(3'b011, 8'hF0, 8'h0C, 1'b1);
        n_cmp++;
        if (obs[13:2] !== {8'hFC, 4'b0000}) begin
            n_err++; $display("FAIL ors: got %h want %h", obs[13:2], {8'hFC, 4'b0000});
        end
        // ANDS to zero: zero flag set on logic op
        apply_op(3'b001, 8'hF0, 8'h0F, 1'b0);
        n_cmp++;
        if (obs[13:2] !== {8'h00, 4'b0001}) begin
            n_err++; $display("FAIL ands_zero: got %h want %h", obs[13:2], {8'h00, 4'b0001});
        end
    endtask

    task automatic test_back_to_back();
        resultReady = 1'b0;
        tick();  // drain any previous entry cannot happen with ready low; state idles
        resultReady = 1'b1;
        tick();  // make sure the slot is empty
        resultReady = 1'b0;
        apply_op(3'b000, 8'h10, 8'h20, 1'b0);
        aluOp = 3'b000; a_REG_IN = 8'h01; b_REG_IN = 8'h01; carryIn = 1'b0; opValid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({adderHold, resultValid, opReady} !== {8'h30, 2'b10}) begin
                n_err++; $display("FAIL hold_frozen_%0d: got %h want %h", i,
                                  {adderHold, resultValid, opReady}, {8'h30, 2'b10});
            end
            tick();
        end
        resultReady = 1'b1;
        #1;
        n_cmp++;
        if (opReady !== 1'b1) begin
            n_err++; $display("FAIL pop_ready: got %b want 1", opReady);
        end
        tick();
        opValid = 1'b0; resultReady = 1'b0;
        #1;
        n_cmp++;
        if ({adderHold, resultValid} !== {8'h02, 1'b1}) begin
            n_err++; $display("FAIL b2b_result: got %h want %h", {adderHold, resultValid}, {8'h02, 1'b1});
        end
    endtask

    task automatic test_flush_reserved();
        // FULL with 02 held; flush beats opValid
        flush = 1'b1; opValid = 1'b1; aluOp = 3'b000; a_REG_IN = 8'h40; b_REG_IN = 8'h40;
        #1;
        n_cmp++;
        if (opReady !== 1'b0) begin
            n_err++; $display("FAIL flush_ready: got %b want 0", opReady);
        end
        tick();
        flush = 1'b0; opValid = 1'b0;
        #1;
        n_cmp++;
        if (obs[13:1] !== {8'h02, 4'b0000, 1'b0}) begin
            n_err++; $display("FAIL flush_hold: got %h want %h", obs[13:1], {8'h02, 5'b00000});
        end
        // reserved op 110
        resultReady = 1'b1;
        apply_op(3'b110, 8'h12, 8'h34, 1'b1);
        n_cmp++;
        if ({obs[13:2], opError} !== {8'h00, 4'b0001, 1'b1}) begin
            n_err++; $display("FAIL rsv_result: got %h want %h", {obs[13:2], opError}, {8'h00, 5'b00011});
        end
        tick();
        n_cmp++;
        if (opError !== 1'b0) begin
            n_err++; $display("FAIL rsv_pulse: got %b want 0", opError);
        end
    endtask

    task automatic test_async_reset_bus();
        resultReady = 1'b0;
        apply_op(3'b000, 8'h7F, 8'h01, 1'b0);
        n_cmp++;
        if (obs[13:1] !== {8'h80, 4'b0110, 1'b1}) begin
            n_err++; $display("FAIL pre_reset: got %h want %h", obs[13:1], {8'h80, 5'b01101});
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs[13:1] !== {8'h00, 4'b0001, 1'b0}) begin
            n_err++; $display("FAIL async_reset: got %h want %h", obs[13:1], {8'h00, 5'b00010});
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (opReady !== 1'b1) begin
            n_err++; $display("FAIL post_reset_ready: got %b want 1", opReady);
        end
        tick();
        resultReady = 1'b1;
        apply_op(3'b000, 8'h50, 8'h0A, 1'b0);
        addHoldToAddrLow_EN = 1'b1; addHoldToSystemBus_EN = 1'b1;
        #1;
        n_cmp++;
        if ({addressLowOut, systemBusOut} !== 16'h5A5A) begin
            n_err++; $display("FAIL bus_both: got %h want 5a5a", {addressLowOut, systemBusOut});
        end
        addHoldToSystemBus_EN = 1'b0;
        #1;
        n_cmp++;
        if ({addressLowOut, systemBusOut} !== 16'h5A00) begin
            n_err++; $display("FAIL bus_addr_only: got %h want 5a00", {addressLowOut, systemBusOut});
        end
        addHoldToAddrLow_EN = 1'b0; addHoldToSystemBus_EN = 1'b1;
        tick();  // slot popped; bus still shows the held value
        n_cmp++;
        if ({addressLowOut, systemBusOut, resultValid} !== {16'h005A, 1'b0}) begin
            n_err++; $display("FAIL bus_after_pop: got %h want %h", {addressLowOut, systemBusOut, resultValid}, {16'h005A, 1'b0});
        end
        addHoldToSystemBus_EN = 1'b0;
        #1;
        n_cmp++;
        if ({addressLowOut, systemBusOut} !== 16'h0000) begin
            n_err++; $display("FAIL bus_off: got %h want 0000", {addressLowOut, systemBusOut});
        end
    endtask

    initial begin
        test_reset();
        test_sums();
        test_logic_shift();
        test_back_to_back();
        test_flush_reserved();
        test_async_reset_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
